mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAIN_ADDR_WIDTH, default 1, main memory address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter READ_LATENCY, default 1, fixed memory read latency in cycles (legal 1..4).
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, consecutive stream denials before a forced stream grant.
REQ-005 Ports, in order:
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- core_read  in  1  core read request.
- core_read_address  in  MAIN_ADDR_WIDTH  core read address.
- core_write  in  1  core write request.
- core_write_address  in  MAIN_ADDR_WIDTH  core write address.
- core_write_value  in  WORD_WIDTH  core write data.
- core_ready  out  1  core request(s) fully accepted this cycle.
- core_rdata_valid  out  1  core read data valid.
- stream_valid  in  1  stream request pending.
- stream_we  in  1  1 = stream-in write, 0 = stream-out read.
- stream_address  in  MAIN_ADDR_WIDTH  stream address.
- stream_wdata  in  WORD_WIDTH  stream write data.
- stream_ready  out  1  stream request accepted this cycle.
- stream_rdata_valid  out  1  stream read data valid.
- mem_re, mem_we  out  1 each  memory strobes, never both high.
- mem_addr  out  MAIN_ADDR_WIDTH  memory address.
- mem_wdata  out  WORD_WIDTH  memory write data.
- mem_rdata  in  WORD_WIDTH  memory read data, READ_LATENCY cycles after mem_re.
- rdata  out  WORD_WIDTH  mem_rdata passed through.

Function
REQ-006 SHALL issue at most one memory operation per cycle.
REQ-007 Core SHALL have priority over stream unless REQ-013 applies.
REQ-008 Core read and core write in one cycle: SHALL issue the write in the first cycle (core_ready=0), enter state SPLIT, then issue the latched read address in the next cycle with core_ready=1; return to IDLE.
REQ-009 States: IDLE, SPLIT. In SPLIT, the deferred core read SHALL win regardless of stream_valid or starvation count.
REQ-010 Single core read or write in IDLE: issued same cycle, core_ready=1 combinationally.
REQ-011 stream_ready SHALL assert only in a cycle where the stream op is issued; stream holds address/data until stream_ready.
REQ-012 Each mem_re SHALL push a 2-bit tag (none/core/stream) into a READ_LATENCY-deep shift register; tag at the output stage drives core_rdata_valid or stream_rdata_valid; idle cycles push none.
REQ-013 Starvation counter (when compiled in): increments each cycle stream_valid=1 and stream not granted; saturates at STARVE_LIMIT; at STARVE_LIMIT the stream SHALL be granted in IDLE, core_ready=0 that cycle; counter clears on any stream grant or stream_valid=0.
REQ-014 With no request, mem_re=mem_we=0; mem_addr/mem_wdata don't-care.
REQ-015 Address/data outputs SHALL be combinational from the winning requester; strobes and tags registered state only as stated.

Reset
REQ-016 reset_n low SHALL asynchronously force state IDLE, tag pipe all none, starvation counter 0; core_ready, stream_ready, core_rdata_valid, stream_rdata_valid, mem_re, mem_we all 0 while reset_n is low.
REQ-017 Reset during SPLIT SHALL drop the deferred read; reads in flight SHALL produce no valid pulse.

Configuration
REQ-018 Macro MEM_ARBITER_STARVE_EN: defined -> REQ-013 starvation counter present; undefined -> strict core priority, no counter, STARVE_LIMIT unused.

Structure
REQ-019 Shared package core0_pkg SHALL hold the arbiter state enum (IDLE, SPLIT) and read tag enum (TAG_NONE, TAG_CORE, TAG_STREAM).
REQ-020 Tag shift register SHALL be sub-module mem_tag_pipe, parameterised by READ_LATENCY.

Verification
REQ-021 Core read 0x10 alone, READ_LATENCY=2 -> mem_re, mem_addr=0x10 cycle 0; core_rdata_valid cycle 2 only.
REQ-022 Core write 0x20/0xDEAD plus read 0x21 -> cycle 0 mem_we addr 0x20, core_ready=0; cycle 1 mem_re addr 0x21, core_ready=1.
REQ-023 Stream write 0x30 with core idle -> mem_we addr 0x30, stream_ready=1 same cycle.
REQ-024 STARVE_EN, STARVE_LIMIT=4, continuous core reads and stream read -> stream granted cycle 4, core_ready=0 that cycle, stream_rdata_valid READ_LATENCY later; without macro, stream never granted.
REQ-025 reset_n low in SPLIT with read in flight -> no mem_re next cycle, no rdata_valid pulses, state IDLE.

Source files
------------

// File: rtl/core0_pkg.sv
// Shared types for the memory arbiter: arbitration state and read-return tag.
// Latency: n/a (types only).
// Backpressure: n/a.
package core0_pkg;

  // IDLE arbitrates normally; SPLIT owns the cycle for a deferred core read.
  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } arb_state_t;

  // Owner of a read that is still travelling through the memory pipeline.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_CORE   = 2'd1,
    TAG_STREAM = 2'd2
  } rd_tag_t;

endpackage

// File: rtl/mem_tag_pipe.sv
// Read-owner tag delay line, one stage per cycle of memory read latency.
// Latency: tag_out is tag_in delayed by exactly READ_LATENCY cycles.
// Backpressure: none; a tag is shifted in every cycle (TAG_NONE when idle).
module mem_tag_pipe
  import core0_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [READ_LATENCY];

  // Shift register; reset empties it so in-flight reads never report valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe[i] <= TAG_NONE;
      end
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tag_out = pipe[READ_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between a core (read+write) and a stream port; MEM_ARBITER_STARVE_EN adds stream anti-starvation.
// Latency: grants are combinational in the request cycle; read data valid READ_LATENCY cycles after mem_re.
// Backpressure: core_ready/stream_ready high only when that requester's op issues; requesters hold until ready.
module mem_arbiter
  import core0_pkg::*;
#(
  parameter int MAIN_ADDR_WIDTH = 1,
  parameter int WORD_WIDTH      = 32,
  parameter int READ_LATENCY    = 1,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       core_read,
  input  logic [MAIN_ADDR_WIDTH-1:0] core_read_address,
  input  logic                       core_write,
  input  logic [MAIN_ADDR_WIDTH-1:0] core_write_address,
  input  logic [WORD_WIDTH-1:0]      core_write_value,
  output logic                       core_ready,
  output logic                       core_rdata_valid,
  input  logic                       stream_valid,
  input  logic                       stream_we,
  input  logic [MAIN_ADDR_WIDTH-1:0] stream_address,
  input  logic [WORD_WIDTH-1:0]      stream_wdata,
  output logic                       stream_ready,
  output logic                       stream_rdata_valid,
  output logic                       mem_re,
  output logic                       mem_we,
  output logic [MAIN_ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0]      mem_wdata,
  input  logic [WORD_WIDTH-1:0]      mem_rdata,
  output logic [WORD_WIDTH-1:0]      rdata
);

  arb_state_t                 state, state_nxt;
  logic [MAIN_ADDR_WIDTH-1:0] split_addr;
  logic                       latch_split;
  logic                       grant_stream;
  logic                       core_ready_c;
  logic                       re_c, we_c;
  logic                       starve_force;
  rd_tag_t                    tag_in, tag_out;

`ifdef MEM_ARBITER_STARVE_EN
  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  assign starve_force = stream_valid && (starve_cnt == CNT_MAX);

  // Count consecutive denied stream cycles, saturating; any grant or idle stream clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!stream_valid || grant_stream) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // State register and the read address parked while the write half of a split goes out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      split_addr <= '0;
    end else begin
      state <= state_nxt;
      if (latch_split) begin
        split_addr <= core_read_address;
      end
    end
  end

  // Arbitration: deferred read, then forced stream, then core, then stream.
  always_comb begin
    state_nxt    = state;
    latch_split  = 1'b0;
    grant_stream = 1'b0;
    core_ready_c = 1'b0;
    re_c         = 1'b0;
    we_c         = 1'b0;
    mem_addr     = core_read_address;
    mem_wdata    = core_write_value;
    case (state)
      SPLIT: begin
        re_c         = 1'b1;
        mem_addr     = split_addr;
        core_ready_c = 1'b1;
        state_nxt    = IDLE;
      end
      IDLE: begin
        if (starve_force) begin
          grant_stream = 1'b1;
        end else if (core_read && core_write) begin
          we_c        = 1'b1;
          mem_addr    = core_write_address;
          latch_split = 1'b1;
          state_nxt   = SPLIT;
        end else if (core_read) begin
          re_c         = 1'b1;
          core_ready_c = 1'b1;
        end else if (core_write) begin
          we_c         = 1'b1;
          mem_addr     = core_write_address;
          core_ready_c = 1'b1;
        end else if (stream_valid) begin
          grant_stream = 1'b1;
        end
        if (grant_stream) begin
          re_c      = !stream_we;
          we_c      = stream_we;
          mem_addr  = stream_address;
          mem_wdata = stream_wdata;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshakes and strobes are held low for the whole time reset is asserted.
  assign mem_re       = reset_n & re_c;
  assign mem_we       = reset_n & we_c;
  assign core_ready   = reset_n & core_ready_c;
  assign stream_ready = reset_n & grant_stream;

  assign tag_in = !mem_re      ? TAG_NONE   :
                  grant_stream ? TAG_STREAM : TAG_CORE;

  mem_tag_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign core_rdata_valid   = (tag_out == TAG_CORE);
  assign stream_rdata_valid = (tag_out == TAG_STREAM);
  assign rdata              = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts each cycle's memory op, handshakes and read returns.
// Latency: expectations are checked on the falling edge of the cycle they describe.
// Backpressure: stimulus holds core/stream requests until the model says they were accepted.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int WW = 32;
  localparam int L  = 2;
  localparam int SL = 4;
`ifdef MEM_ARBITER_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          core_read = 1'b0, core_write = 1'b0;
  logic [AW-1:0] core_read_address = '0, core_write_address = '0;
  logic [WW-1:0] core_write_value = '0;
  logic          core_ready, core_rdata_valid;
  logic          stream_valid = 1'b0, stream_we = 1'b0;
  logic [AW-1:0] stream_address = '0;
  logic [WW-1:0] stream_wdata = '0;
  logic          stream_ready, stream_rdata_valid;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata = '0;
  logic [WW-1:0] rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAIN_ADDR_WIDTH (AW),
    .WORD_WIDTH      (WW),
    .READ_LATENCY    (L),
    .STARVE_LIMIT    (SL)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .core_read          (core_read),
    .core_read_address  (core_read_address),
    .core_write         (core_write),
    .core_write_address (core_write_address),
    .core_write_value   (core_write_value),
    .core_ready         (core_ready),
    .core_rdata_valid   (core_rdata_valid),
    .stream_valid       (stream_valid),
    .stream_we          (stream_we),
    .stream_address     (stream_address),
    .stream_wdata       (stream_wdata),
    .stream_ready       (stream_ready),
    .stream_rdata_valid (stream_rdata_valid),
    .mem_re             (mem_re),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .rdata              (rdata)
  );

  typedef struct packed {
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    logic          cr_rdy;
    logic          st_rdy;
    logic          crv;
    logic          srv;
    logic [WW-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: deferred core reads, denial count, memory image, pending returns.
  logic [AW-1:0] defer_q[$];
  int            wait_cnt = 0;
  logic [WW-1:0] mmem [256];
  int            rv_who [int];
  logic [WW-1:0] rv_data [int];

  // Memory responder state, fed only by what the DUT actually puts on the bus.
  logic [WW-1:0] rmem [256];
  logic [WW-1:0] resp_data [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push what the model says must happen in that cycle.
  task automatic drive(input bit rst, input bit cr, input logic [AW-1:0] cra,
                       input bit cw, input logic [AW-1:0] cwa, input logic [WW-1:0] cwv,
                       input bit sv, input bit swe, input logic [AW-1:0] sa,
                       input logic [WW-1:0] swd, output bit c_acc, output bit s_acc);
    exp_t          e;
    bit            sg, op_rd, op_wr;
    int            who;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
    @(posedge clk);
    #1;
    reset_n = !rst;
    core_read = cr; core_read_address = cra;
    core_write = cw; core_write_address = cwa; core_write_value = cwv;
    stream_valid = sv; stream_we = swe; stream_address = sa; stream_wdata = swd;
    e = '0;
    c_acc = 1'b0;
    s_acc = 1'b0;
    if (rst) begin
      defer_q.delete();
      wait_cnt = 0;
      rv_who.delete();
      rv_data.delete();
      exp_q.push_back(e);
      return;
    end
    if (rv_who.exists(cyc)) begin
      e.crv = (rv_who[cyc] == 1);
      e.srv = (rv_who[cyc] == 2);
      e.rd  = rv_data[cyc];
      rv_who.delete(cyc);
    end
    sg = 0; op_rd = 0; op_wr = 0; who = 1; a = '0; d = '0;
    if (defer_q.size() > 0) begin
      op_rd = 1; a = defer_q.pop_front(); e.cr_rdy = 1;
    end else if (STARVE && sv && wait_cnt >= SL) begin
      sg = 1;
    end else if (cr && cw) begin
      op_wr = 1; a = cwa; d = cwv; defer_q.push_back(cra);
    end else if (cr) begin
      op_rd = 1; a = cra; e.cr_rdy = 1;
    end else if (cw) begin
      op_wr = 1; a = cwa; d = cwv; e.cr_rdy = 1;
    end else if (sv) begin
      sg = 1;
    end
    if (sg) begin
      who = 2; e.st_rdy = 1; a = sa; d = swd; op_rd = !swe; op_wr = swe;
    end
    if (sv && !sg) wait_cnt = (wait_cnt + 1 > SL) ? SL : wait_cnt + 1;
    else           wait_cnt = 0;
    e.re = op_rd; e.we = op_wr; e.addr = a; e.wdata = d;
    if (op_wr) mmem[a] = d;
    if (op_rd) begin
      rv_who[cyc + L]  = who;
      rv_data[cyc + L] = mmem[a];
    end
    c_acc = e.cr_rdy;
    s_acc = e.st_rdy;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    bit ca, sa_;
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, '0, '0, 0, 0, '0, '0, ca, sa_);
  endtask

  // Monitor: compare the DUT's cycle against the oldest prediction; also act as the memory.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_re", WW'(mem_re), WW'(e.re));
      chk("mem_we", WW'(mem_we), WW'(e.we));
      chk("core_ready", WW'(core_ready), WW'(e.cr_rdy));
      chk("stream_ready", WW'(stream_ready), WW'(e.st_rdy));
      chk("core_rdata_valid", WW'(core_rdata_valid), WW'(e.crv));
      chk("stream_rdata_valid", WW'(stream_rdata_valid), WW'(e.srv));
      if (e.re || e.we) chk("mem_addr", WW'(mem_addr), WW'(e.addr));
      if (e.we)         chk("mem_wdata", mem_wdata, e.wdata);
      if (e.crv || e.srv) chk("rdata", rdata, e.rd);
    end
    if (mem_we) rmem[mem_addr] = mem_wdata;
    if (mem_re) resp_data[cyc + L] = rmem[mem_addr];
  end

  // Memory read port: return the word addressed L cycles ago, otherwise noise.
  always @(posedge clk) begin
    #1;
    if (resp_data.exists(cyc)) begin
      mem_rdata = resp_data[cyc];
      resp_data.delete(cyc);
    end else begin
      mem_rdata = $urandom;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d act=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ca, sa_;
    bit            cr, cw, sv, swe;
    logic [AW-1:0] cra, cwa, sad;
    logic [WW-1:0] cwv, swd;
    int            mode;
    for (int i = 0; i < 256; i++) begin
      mmem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      rmem[i] = mmem[i];
    end

    // Reset with every request asserted: nothing may be granted or strobed.
    drive(1, 1, 8'h01, 1, 8'h02, 32'h1, 1, 1, 8'h03, 32'h2, ca, sa_);
    drive(1, 1, 8'h01, 1, 8'h02, 32'h1, 1, 0, 8'h03, 32'h2, ca, sa_);
    idle(1);

    // Lone core read; data returns L cycles later.
    drive(0, 1, 8'h10, 0, '0, '0, 0, 0, '0, '0, ca, sa_);
    idle(3);

    // Core write + read together: write first, deferred read next cycle.
    drive(0, 1, 8'h21, 1, 8'h20, 32'hDEAD, 0, 0, '0, '0, ca, sa_);
    drive(0, 1, 8'h21, 1, 8'h20, 32'hDEAD, 0, 0, '0, '0, ca, sa_);
    idle(3);

    // Stream write with core idle, then stream read back of the same word.
    drive(0, 0, '0, 0, '0, '0, 1, 1, 8'h30, 32'h1234_5678, ca, sa_);
    drive(0, 0, '0, 0, '0, '0, 1, 0, 8'h30, '0, ca, sa_);
    idle(3);

    // Continuous core reads against a waiting stream read.
    for (int i = 0; i < 10; i++)
      drive(0, 1, AW'(8'h40 + i), 0, '0, '0, 1, 0, 8'h30, '0, ca, sa_);
    idle(4);

    // Reset while SPLIT holds a deferred read and an earlier read is in flight.
    drive(0, 1, 8'h11, 0, '0, '0, 0, 0, '0, '0, ca, sa_);
    drive(0, 1, 8'h12, 1, 8'h13, 32'hBEEF, 0, 0, '0, '0, ca, sa_);
    drive(1, 1, 8'h12, 1, 8'h13, 32'hBEEF, 0, 0, '0, '0, ca, sa_);
    drive(1, 0, '0, 0, '0, '0, 0, 0, '0, '0, ca, sa_);
    idle(2);
    drive(0, 0, '0, 1, 8'h14, 32'h5, 0, 0, '0, '0, ca, sa_);
    idle(3);

    // Randomised traffic with requests held until accepted.
    cr = 0; cw = 0; sv = 0; swe = 0;
    cra = '0; cwa = '0; sad = '0; cwv = '0; swd = '0;
    for (int k = 0; k < 1500; k++) begin
      if (!cr && !cw && $urandom_range(0, 3) != 0) begin
        mode = $urandom_range(0, 2);
        cr   = (mode != 1);
        cw   = (mode != 0);
        cra  = AW'($urandom_range(0, 15));
        cwa  = AW'($urandom_range(0, 15));
        cwv  = $urandom;
      end
      if (!sv && $urandom_range(0, 2) == 0) begin
        sv  = 1;
        swe = 1'($urandom_range(0, 1));
        sad = AW'($urandom_range(0, 15));
        swd = $urandom;
      end
      if ($urandom_range(0, 199) == 0) begin
        drive(1, cr, cra, cw, cwa, cwv, sv, swe, sad, swd, ca, sa_);
        cr = 0; cw = 0; sv = 0;
      end else begin
        drive(0, cr, cra, cw, cwa, cwv, sv, swe, sad, swd, ca, sa_);
        if (ca) begin cr = 0; cw = 0; end
        if (sa_) sv = 0;
      end
    end
    idle(L + 3);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
